// File: rtl/beam_result_uart_streamer.sv
// beam_result_uart_streamer
//   Captures 40-bit summed beam samples into an on-chip buffer while sumflag is
//   high. It then streams them to the host over an 8N1 UART. A frame is a 3-byte
//   header {SYNC_BYTE, count[7:0], count[9:8]}, then 5 bytes per sample, least
//   significant byte first.
// Ports
//   clk            system clock
//   rst            synchronous, active-low reset
//   summed_value   signed beam sum from the sum stage
//   sumflag        high while the sum stage is emitting samples
//   uart_tx        UART serial out, idle high
//   busy           high while capturing or sending
//   capture_count  samples captured in the current/last frame
//   frame_done     1-cycle pulse after the last stop bit of a frame
module beam_result_uart_streamer #(
    parameter int          NUM_SAMPLES    = 540,
    parameter int          CAPTURE_STRIDE = 2,
    parameter int          CAPTURE_OFFSET = 1,
    parameter int          CLKS_PER_BIT   = 434,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] summed_value,
    input  logic        sumflag,
    output logic        uart_tx,
    output logic        busy,
    output logic [9:0]  capture_count,
    output logic        frame_done
);

    localparam int   ADDR_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
    localparam int   PHASE_W     = (CAPTURE_STRIDE > 1) ? $clog2(CAPTURE_STRIDE) : 1;
    localparam int   BAUD_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic OFFSET_ZERO = (CAPTURE_OFFSET == 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CAPTURE   = 3'd1,
        ST_SEND_HDR  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic                sumflag_prev_r;
    logic                rise_s;
    logic [PHASE_W-1:0]  phase_r;
    logic [9:0]          capture_count_r;
    logic [39:0]         sample_mem_r [NUM_SAMPLES];
    logic [39:0]         rd_data_r;
    logic [BAUD_W-1:0]   baud_cnt_r;
    logic [3:0]          bit_idx_r;
    logic [2:0]          byte_idx_r;
    logic [9:0]          sample_idx_r;
    logic                cap_we_s;
    logic [ADDR_W-1:0]   cap_addr_s;
    logic                rd_en_s;
    logic [ADDR_W-1:0]   rd_addr_s;
    logic                sending_s;
    logic                baud_end_s;
    logic                byte_end_s;
    logic                hdr_last_s;
    logic                data_last_byte_s;
    logic [7:0]          tx_byte_s;
    logic                tx_bit_s;
    logic                busy_s;
    logic                done_s;
    logic                uart_tx_r;
    logic                busy_r;
    logic                frame_done_r;

    // Shared decode of edge, bit-timing and byte-position conditions.
    always_comb begin
        rise_s           = sumflag & ~sumflag_prev_r;
        sending_s        = (state_r == ST_SEND_HDR) || (state_r == ST_SEND_DATA);
        baud_end_s       = (baud_cnt_r == BAUD_W'(CLKS_PER_BIT - 1));
        byte_end_s       = baud_end_s && (bit_idx_r == 4'd9);
        hdr_last_s       = (state_r == ST_SEND_HDR) && (byte_idx_r == 3'd2);
        data_last_byte_s = (state_r == ST_SEND_DATA) && (byte_idx_r == 3'd4);
    end

    // Capture write strobe; the arming cycle itself is phase 0.
    always_comb begin
        cap_we_s   = 1'b0;
        cap_addr_s = '0;
        if (state_r == ST_IDLE) begin
            cap_we_s = rise_s && OFFSET_ZERO;
        end else if (state_r == ST_CAPTURE) begin
            cap_we_s   = sumflag && (phase_r == PHASE_W'(CAPTURE_OFFSET)) &&
                         (capture_count_r < 10'(NUM_SAMPLES));
            cap_addr_s = capture_count_r[ADDR_W-1:0];
        end else begin
            cap_we_s = 1'b0;
        end
    end

    // Buffer read port: word 0 during the header, next word during the stop
    // bit of a sample's last byte so it is ready before that sample's first data bit.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_addr_s = '0;
        if (state_r == ST_SEND_HDR) begin
            rd_en_s = 1'b1;
        end else if (data_last_byte_s && (bit_idx_r == 4'd9) &&
                     ((sample_idx_r + 10'd1) < capture_count_r)) begin
            rd_en_s   = 1'b1;
            rd_addr_s = sample_idx_r[ADDR_W-1:0] + ADDR_W'(1);
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Sample buffer: contents are don't-care after reset, so it has no reset.
    always_ff @(posedge clk) begin
        if (cap_we_s) begin
            sample_mem_r[cap_addr_s] <= summed_value;
        end
        if (rd_en_s) begin
            rd_data_r <= sample_mem_r[rd_addr_s];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) state_next_s = ST_CAPTURE;
                else        state_next_s = ST_IDLE;
            end
            ST_CAPTURE: begin
                if (capture_count_r == 10'(NUM_SAMPLES))  state_next_s = ST_SEND_HDR;
                else if (!sumflag && capture_count_r == 10'd0) state_next_s = ST_DONE;
                else if (!sumflag)                          state_next_s = ST_SEND_HDR;
                else                                        state_next_s = ST_CAPTURE;
            end
            ST_SEND_HDR: begin
                if (byte_end_s && hdr_last_s) state_next_s = ST_SEND_DATA;
                else                          state_next_s = ST_SEND_HDR;
            end
            ST_SEND_DATA: begin
                if (byte_end_s && data_last_byte_s &&
                    (sample_idx_r == capture_count_r - 10'd1)) state_next_s = ST_DONE;
                else                                           state_next_s = ST_SEND_DATA;
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: byte and bit to drive, busy/done flags.
    always_comb begin
        tx_byte_s = 8'h00;
        tx_bit_s  = 1'b1;
        case (state_r)
            ST_SEND_HDR: begin
                case (byte_idx_r)
                    3'd0:    tx_byte_s = SYNC_BYTE;
                    3'd1:    tx_byte_s = capture_count_r[7:0];
                    3'd2:    tx_byte_s = {6'b000000, capture_count_r[9:8]};
                    default: tx_byte_s = 8'h00;
                endcase
            end
            ST_SEND_DATA: begin
                case (byte_idx_r)
                    3'd0:    tx_byte_s = rd_data_r[7:0];
                    3'd1:    tx_byte_s = rd_data_r[15:8];
                    3'd2:    tx_byte_s = rd_data_r[23:16];
                    3'd3:    tx_byte_s = rd_data_r[31:24];
                    3'd4:    tx_byte_s = rd_data_r[39:32];
                    default: tx_byte_s = 8'h00;
                endcase
            end
            default: tx_byte_s = 8'h00;
        endcase
        if (sending_s) begin
            case (bit_idx_r)
                4'd0:    tx_bit_s = 1'b0;
                4'd9:    tx_bit_s = 1'b1;
                default: tx_bit_s = tx_byte_s[3'(bit_idx_r - 4'd1)];
            endcase
        end else begin
            tx_bit_s = 1'b1;
        end
        busy_s = (state_r == ST_CAPTURE) || sending_s;
        done_s = (state_r == ST_DONE);
    end

    // Capture bookkeeping: edge history, stride phase and sample count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sumflag_prev_r  <= sumflag;   // a level already high at reset must not arm
            phase_r         <= '0;
            capture_count_r <= 10'd0;
        end else begin
            sumflag_prev_r <= sumflag;
            if (state_r == ST_IDLE && rise_s) begin
                phase_r         <= PHASE_W'(1 % CAPTURE_STRIDE);
                capture_count_r <= OFFSET_ZERO ? 10'd1 : 10'd0;
            end else if (state_r == ST_CAPTURE) begin
                phase_r <= (phase_r == PHASE_W'(CAPTURE_STRIDE - 1)) ? '0 : phase_r + PHASE_W'(1);
                if (cap_we_s) begin
                    capture_count_r <= capture_count_r + 10'd1;
                end
            end
        end
    end

    // UART bit timing plus byte/sample position; idles at zero outside sending.
    always_ff @(posedge clk) begin
        if (!rst || !sending_s) begin
            baud_cnt_r   <= '0;
            bit_idx_r    <= 4'd0;
            byte_idx_r   <= 3'd0;
            sample_idx_r <= 10'd0;
        end else begin
            baud_cnt_r <= baud_end_s ? '0 : baud_cnt_r + BAUD_W'(1);
            if (baud_end_s) begin
                bit_idx_r <= (bit_idx_r == 4'd9) ? 4'd0 : bit_idx_r + 4'd1;
            end
            if (byte_end_s) begin
                byte_idx_r <= (hdr_last_s || data_last_byte_s) ? 3'd0 : byte_idx_r + 3'd1;
                if (data_last_byte_s) begin
                    sample_idx_r <= sample_idx_r + 10'd1;
                end
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            uart_tx_r    <= 1'b1;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            uart_tx_r    <= tx_bit_s;
            busy_r       <= busy_s;
            frame_done_r <= done_s;
        end
    end

    assign uart_tx       = uart_tx_r;
    assign busy          = busy_r;
    assign frame_done    = frame_done_r;
    assign capture_count = capture_count_r;

endmodule

// File: tb/tb_beam_result_uart_streamer.sv
module tb_beam_result_uart_streamer;
    localparam int CPB    = 4;
    localparam int NS     = 4;
    localparam int STRIDE = 2;
    localparam int OFFSET = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sumflag = 1'b0;
    logic [39:0] summed_value = 40'd0;
    logic        uart_tx;
    logic        busy;
    logic [9:0]  capture_count;
    logic        frame_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          done_q[$];
    int          first_start = -1;
    int          frame_err = 0;
    int          exp_n = 0;
    logic [39:0] vals [64];
    logic [7:0]  mon_byte;

    beam_result_uart_streamer #(
        .NUM_SAMPLES(NS), .CAPTURE_STRIDE(STRIDE), .CAPTURE_OFFSET(OFFSET),
        .CLKS_PER_BIT(CPB), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .summed_value(summed_value), .sumflag(sumflag),
        .uart_tx(uart_tx), .busy(busy), .capture_count(capture_count),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // UART receiver: detect start, sample each bit mid-way.
    always begin
        @(negedge clk);
        if (uart_tx === 1'b0) begin
            if (first_start < 0) first_start = cyc;
            repeat (CPB / 2) @(negedge clk);
            if (uart_tx !== 1'b0) frame_err++;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_byte[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (uart_tx !== 1'b1) frame_err++;
            rx_q.push_back(mon_byte);
        end
    end

    always @(negedge clk) if (frame_done === 1'b1) done_q.push_back(cyc);

    task automatic clear_mon();
        rx_q.delete();
        done_q.delete();
        first_start = -1;
        frame_err = 0;
    endtask

    task automatic randomize_vals();
        for (int i = 0; i < 64; i++) vals[i] = {8'($urandom), 32'($urandom)};
    endtask

    // Hold sumflag high for h cycles presenting vals[phase] on each cycle.
    task automatic pulse(input int h);
        @(posedge clk); #1;
        for (int p = 0; p < h; p++) begin
            sumflag = 1'b1;
            summed_value = vals[p];
            @(posedge clk); #1;
        end
        sumflag = 1'b0;
        summed_value = {8'($urandom), 32'($urandom)};
    endtask

    // Reference: which phases are captured, and the resulting byte stream.
    task automatic model(input int h);
        logic [39:0] s [$];
        exp_q.delete();
        for (int p = 0; p < h; p++)
            if ((p % STRIDE) == OFFSET && s.size() < NS) s.push_back(vals[p]);
        exp_n = s.size();
        if (exp_n > 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(exp_n));
            exp_q.push_back(8'(exp_n >> 8));
            foreach (s[i]) for (int k = 0; k < 5; k++) exp_q.push_back(8'(s[i] >> (8 * k)));
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_q.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; sumflag = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_tx got=%b exp=1", uart_tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (capture_count !== 10'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", capture_count); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", frame_done); end
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rx_q.size() != 0) begin failures++; $display("FAIL held_high_arm busy=%b bytes=%0d exp busy=0 bytes=0", busy, rx_q.size()); end
        sumflag = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_known_frame();
        bit ok;
        randomize_vals();
        vals[1] = 40'd1; vals[3] = 40'hFF_FFFF_FFFF; vals[5] = 40'h12_3456_789A; vals[7] = 40'd0;
        model(8);
        clear_mon();
        pulse(8);
        wait_done(2000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL known_done_timeout got=0 exp=1"); end
        checks++; if (capture_count !== 10'd4) begin failures++; $display("FAIL known_count got=%0d exp=4", capture_count); end
        checks++; if (rx_q.size() != 23) begin failures++; $display("FAIL known_nbytes got=%0d exp=23", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL known_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        checks++; if (ok && done_q[0] - first_start != 230 * CPB) begin failures++; $display("FAIL known_frame_len got=%0d exp=%0d", done_q[0] - first_start, 230 * CPB); end
        checks++; if (frame_err != 0 || busy !== 1'b0) begin failures++; $display("FAIL known_framing err=%0d busy=%b exp 0/0", frame_err, busy); end
    endtask

    task automatic test_short_frame();
        bit ok;
        randomize_vals();
        model(6);
        clear_mon();
        pulse(6);
        wait_done(2000, ok);
        checks++; if (!ok || capture_count !== 10'd3) begin failures++; $display("FAIL short_count got=%0d exp=3 done=%b", capture_count, ok); end
        checks++; if (rx_q.size() != 18) begin failures++; $display("FAIL short_nbytes got=%0d exp=18", rx_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL short_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_overflow_repulse();
        bit ok;
        randomize_vals();
        model(20);
        clear_mon();
        pulse(20);
        repeat (100) @(posedge clk);
        pulse(4);
        wait_done(2000, ok);
        repeat (1200) @(posedge clk);
        #1;
        checks++; if (!ok || capture_count !== 10'd4) begin failures++; $display("FAIL ovf_count got=%0d exp=4 done=%b", capture_count, ok); end
        checks++; if (done_q.size() != 1) begin failures++; $display("FAIL ovf_single_frame got=%0d exp=1", done_q.size()); end
        checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL ovf_nbytes got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_empty_pulse();
        bit ok;
        randomize_vals();
        clear_mon();
        pulse(1);
        wait_done(50, ok);
        repeat (20) @(posedge clk);
        #1;
        checks++; if (!ok) begin failures++; $display("FAIL empty_done got=0 exp=1"); end
        checks++; if (capture_count !== 10'd0) begin failures++; $display("FAIL empty_count got=%0d exp=0", capture_count); end
        checks++; if (rx_q.size() != 0 || first_start >= 0) begin failures++; $display("FAIL empty_uart got=%0d bytes exp=0", rx_q.size()); end
        checks++; if (done_q.size() != 1 || busy !== 1'b0) begin failures++; $display("FAIL empty_idle pulses=%0d busy=%b exp 1/0", done_q.size(), busy); end
    endtask

    task automatic test_random();
        bit ok;
        int h;
        for (int it = 0; it < 5; it++) begin
            randomize_vals();
            h = $urandom_range(2, 14);
            model(h);
            clear_mon();
            pulse(h);
            wait_done(2000, ok);
            checks++; if (!ok || capture_count !== 10'(exp_n)) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d done=%b", it, capture_count, exp_n, ok); end
            checks++; if (rx_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_nbytes got=%0d exp=%0d", it, rx_q.size(), exp_q.size()); end
            for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
                checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, rx_q[i], exp_q[i]); end
            end
            checks++; if (ok && first_start >= 0 && done_q[0] - first_start != (3 + 5 * exp_n) * 10 * CPB) begin
                failures++; $display("FAIL rand%0d_len got=%0d exp=%0d", it, done_q[0] - first_start, (3 + 5 * exp_n) * 10 * CPB);
            end
            repeat (10) @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        randomize_vals();
        clear_mon();
        pulse(8);
        for (int i = 0; i < 2000 && rx_q.size() < 5; i++) @(posedge clk);
        checks++; if (rx_q.size() < 5) begin failures++; $display("FAIL midrst_progress got=%0d exp>=5", rx_q.size()); end
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL midrst_tx got=%b exp=1", uart_tx); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (80) @(posedge clk);
        #1;
        checks++; if (capture_count !== 10'd0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_idle count=%0d busy=%b exp 0/0", capture_count, busy); end
        randomize_vals();
        model(4);
        clear_mon();
        pulse(4);
        wait_done(2000, ok);
        checks++; if (!ok || rx_q.size() != exp_q.size()) begin failures++; $display("FAIL midrst_refr got=%0d bytes exp=%0d done=%b", rx_q.size(), exp_q.size(), ok); end
        checks++; if (rx_q.size() == 0 || rx_q[0] !== 8'hA5) begin failures++; $display("FAIL midrst_sync got=%h exp=a5", (rx_q.size() > 0) ? rx_q[0] : 8'h00); end
        for (int i = 1; i < rx_q.size() && i < exp_q.size(); i++) begin
            checks++; if (rx_q[i] !== exp_q[i]) begin failures++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_short_frame();
        test_overflow_repulse();
        test_empty_pulse();
        test_random();
        test_reset_mid_send();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
